// File: rtl/fetch_pkg.sv
// fetch_pkg: reset address, fetch FSM states and redirect causes shared by the fetch sequencer
package fetch_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;
  typedef enum logic [1:0] {NONE, BR, MRET, TRAP} redir_cause_t;
endpackage

// File: rtl/redirect_arb.sv
// redirect_arb: trap > mret > br priority select plus a pending-target register (ld stores, clr drops); trap/mret ports only with `TRAP_EN
module redirect_arb import fetch_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic        clr,
  input  logic        br_taken,
  input  logic [31:0] br_target,
`ifdef TRAP_EN
  input  logic        trap,
  input  logic [31:0] trap_vec,
  input  logic        mret,
  input  logic [31:0] mepc,
`endif
  output logic        redir_valid,
  output logic [31:0] redir_target,
  output logic [1:0]  redir_cause
);
  redir_cause_t live_c, pend_c, cause;
  logic [31:0] live_t, pend_t;
`ifdef TRAP_EN
  assign live_c = trap ? TRAP : mret ? MRET : br_taken ? BR : NONE;
  assign live_t = trap ? trap_vec : mret ? mepc : br_target;
`else
  assign live_c = br_taken ? BR : NONE;
  assign live_t = br_target;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend_c <= NONE;
      pend_t <= '0;
    end else if (clr) begin
      pend_c <= NONE;
    end else if (ld && live_c != NONE) begin
      pend_c <= live_c;
      pend_t <= live_t;
    end
  assign cause        = (live_c != NONE) ? live_c : pend_c;
  assign redir_target = (live_c != NONE) ? live_t : pend_t;
  assign redir_valid  = cause != NONE;
  assign redir_cause  = cause;
endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: drives next_pc, issues one imem fetch at a time at pc, hands instructions to decode by valid/ready; trap/mret redirect ports only with `TRAP_EN
module fetch_seq import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target
`ifdef TRAP_EN
  ,
  input  logic        trap,
  input  logic [31:0] trap_vec,
  input  logic        mret,
  input  logic [31:0] mepc
`endif
);
  fetch_state_t state, state_n;
  logic kill, kill_n, go, take, redir_valid, unused_cause;
  logic [31:0] req_pc, redir_target;
  logic [1:0] redir_cause;
  redirect_arb u_arb (
    .clk(clk),
    .rst(rst),
    .ld(state == REQ && !imem_gnt),
    .clr(go),
    .br_taken(br_taken),
    .br_target(br_target),
`ifdef TRAP_EN
    .trap(trap),
    .trap_vec(trap_vec),
    .mret(mret),
    .mepc(mepc),
`endif
    .redir_valid(redir_valid),
    .redir_target(redir_target),
    .redir_cause(redir_cause)
  );
  assign unused_cause = ^redir_cause;
  assign go         = state == REQ && imem_gnt;
  assign take       = state == WAIT && imem_rvalid && !kill && !redir_valid;
  assign imem_req   = state == REQ;
  assign imem_addr  = pc;
  assign inst_valid = state == HOLD;
  // an ungranted request keeps pc so the address stays stable; any redirect is held in the arbiter until the grant
  assign next_pc = rst ? RESET_PC :
                   (state == REQ) ? (!imem_gnt ? pc : redir_valid ? redir_target : pc + 32'd4) :
                   redir_valid ? redir_target : pc;
  always_comb begin
    state_n = state;
    kill_n = kill;
    case (state)
      IDLE: state_n = REQ;
      REQ:
        if (imem_gnt) begin
          state_n = WAIT;
          kill_n = redir_valid;
        end
      WAIT:
        if (imem_rvalid) begin
          state_n = take ? HOLD : REQ;
          kill_n = 1'b0;
        end else if (redir_valid) begin
          kill_n = 1'b1;
        end
      HOLD: if (redir_valid || inst_ready) state_n = REQ;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      kill <= 1'b0;
      req_pc <= '0;
      inst <= '0;
      inst_pc <= '0;
    end else begin
      state <= state_n;
      kill <= kill_n;
      if (go) req_pc <= pc;
      if (take) begin
        inst <= imem_rdata;
        inst_pc <= req_pc;
      end
    end
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed stimulus with a scoreboard of expected fetch addresses and decoded instructions
module tb_fetch_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] pc, next_pc, imem_addr, imem_rdata, inst, inst_pc, br_target, last_addr;
  logic imem_req, imem_gnt, imem_rvalid, inst_valid, inst_ready, br_taken, ovr;
`ifdef TRAP_EN
  logic trap, mret;
  logic [31:0] trap_vec, mepc;
`endif
  logic [31:0] exp_addr[$];
  logic [63:0] exp_inst[$];
  logic [31:0] a;
  logic [63:0] e;
  logic [31:0] pt;
  int n_cmp = 0;
  int n_err = 0;

  fetch_seq dut (
    .clk(clk),
    .rst(rst),
    .pc(pc),
    .next_pc(next_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc),
    .br_taken(br_taken),
    .br_target(br_target)
`ifdef TRAP_EN
    ,
    .trap(trap),
    .trap_vec(trap_vec),
    .mret(mret),
    .mepc(mepc)
`endif
  );

  always #5 clk = ~clk;

  // PC register and memory model: the word at address x reads as ~x unless overridden
  always @(posedge clk or posedge rst) pc <= rst ? 32'h8000_0000 : next_pc;
  always @(posedge clk) if (imem_req && imem_gnt) last_addr <= imem_addr;
  assign imem_rdata = ovr ? 32'hAAAA_AAAA : ~last_addr;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    inst_ready = 1'b0;
    br_taken = 1'b0;
    br_target = '0;
    ovr = 1'b0;
`ifdef TRAP_EN
    trap = 1'b0;
    mret = 1'b0;
    trap_vec = '0;
    mepc = '0;
`endif
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic drain();
    chk("sb_addr_left", exp_addr.size(), 0);
    chk("sb_inst_left", exp_inst.size(), 0);
    exp_addr.delete();
    exp_inst.delete();
  endtask

  always @(negedge clk) if (!rst) begin
    if (imem_req && imem_gnt) begin
      if (exp_addr.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_addr: unexpected fetch of %h", imem_addr);
      end else begin
        a = exp_addr.pop_front();
        chk("sb_addr", imem_addr, a);
      end
    end
    if (inst_valid && inst_ready) begin
      if (exp_inst.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_inst: unexpected instruction %h at %h", inst, inst_pc);
      end else begin
        e = exp_inst.pop_front();
        chk("sb_inst", {inst_pc, inst}, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    inst_ready = 1'b0;
    br_taken = 1'b0;
    br_target = '0;
    ovr = 1'b0;
`ifdef TRAP_EN
    trap = 1'b0;
    mret = 1'b0;
    trap_vec = '0;
    mepc = '0;
`endif
    #1;
    chk("reset_ctl", {imem_req, inst_valid, next_pc}, {1'b0, 1'b0, 32'h8000_0000});
    chk("reset_inst", {inst_pc, inst}, 64'h0);

    // streaming with gnt/rvalid/ready always high
    do_reset();
    imem_gnt = 1'b1;
    imem_rvalid = 1'b1;
    inst_ready = 1'b1;
    exp_addr.push_back(32'h8000_0000);
    exp_addr.push_back(32'h8000_0004);
    exp_addr.push_back(32'h8000_0008);
    exp_inst.push_back({32'h8000_0000, 32'h7FFF_FFFF});
    exp_inst.push_back({32'h8000_0004, 32'h7FFF_FFFB});
    exp_inst.push_back({32'h8000_0008, 32'h7FFF_FFF7});
    chk("idle_no_req", imem_req, 1'b0);
    tick();
    chk("first_req", {imem_req, imem_addr}, {1'b1, 32'h8000_0000});
    tick();
    chk("wait_no_valid", {imem_req, inst_valid}, 2'b00);
    tick();
    chk("valid_gnt_plus2", inst_valid, 1'b1);
    tick();
    chk("req_after_accept", {imem_req, imem_addr}, {1'b1, 32'h8000_0004});
    repeat (5) tick();
    imem_gnt = 1'b0;
    tick();
    tick();
    drain();

    // grant stalled three cycles, branch arrives in the second
    do_reset();
    imem_rvalid = 1'b1;
    inst_ready = 1'b1;
    exp_addr.push_back(32'h8000_0000);
    exp_addr.push_back(32'h8000_0100);
    exp_inst.push_back({32'h8000_0100, 32'h7FFF_FEFF});
    tick();
    chk("stall_addr_c1", {imem_req, imem_addr}, {1'b1, 32'h8000_0000});
    tick();
    br_taken = 1'b1;
    br_target = 32'h8000_0100;
    #1;
    chk("stall_npc_hold", next_pc, 32'h8000_0000);
    tick();
    br_taken = 1'b0;
    chk("stall_addr_c3", {imem_req, imem_addr}, {1'b1, 32'h8000_0000});
    tick();
    imem_gnt = 1'b1;
    #1;
    chk("pending_npc", next_pc, 32'h8000_0100);
    tick();
    tick();
    tick();
    imem_gnt = 1'b0;
    tick();
    tick();
    drain();

    // branch while waiting for data: the returning word is killed
    do_reset();
    imem_gnt = 1'b1;
    inst_ready = 1'b1;
    exp_addr.push_back(32'h8000_0000);
    exp_addr.push_back(32'h8000_0040);
    exp_inst.push_back({32'h8000_0040, 32'h7FFF_FFBF});
    tick();
    tick();
    br_taken = 1'b1;
    br_target = 32'h8000_0040;
    #1;
    chk("wait_redir_npc", next_pc, 32'h8000_0040);
    tick();
    br_taken = 1'b0;
    imem_rvalid = 1'b1;
    ovr = 1'b1;
    #1;
    chk("killed_quiet", {imem_req, inst_valid}, 2'b00);
    tick();
    ovr = 1'b0;
    chk("redir_req", {imem_req, inst_valid, imem_addr}, {1'b1, 1'b0, 32'h8000_0040});
    tick();
    imem_gnt = 1'b0;
    tick();
    tick();
    drain();

    // simultaneous redirect sources in the idle cycle
    do_reset();
    imem_gnt = 1'b1;
    imem_rvalid = 1'b1;
    inst_ready = 1'b1;
    br_taken = 1'b1;
    br_target = 32'h8000_0400;
    pt = 32'h8000_0400;
`ifdef TRAP_EN
    trap = 1'b1;
    trap_vec = 32'h8000_0200;
    mret = 1'b1;
    mepc = 32'h8000_0300;
    pt = 32'h8000_0200;
`endif
    exp_addr.push_back(pt);
    exp_inst.push_back({pt, ~pt});
    #1;
    chk("prio_npc", next_pc, pt);
    tick();
    br_taken = 1'b0;
`ifdef TRAP_EN
    trap = 1'b0;
    mret = 1'b0;
`endif
    tick();
    imem_gnt = 1'b0;
    tick();
    tick();
    drain();

    // decode stalls five cycles in HOLD
    do_reset();
    imem_gnt = 1'b1;
    imem_rvalid = 1'b1;
    exp_addr.push_back(32'h8000_0000);
    exp_inst.push_back({32'h8000_0000, 32'h7FFF_FFFF});
    tick();
    tick();
    imem_gnt = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_data", {inst_pc, inst}, {32'h8000_0000, 32'h7FFF_FFFF});
      chk("hold_ctl", {imem_req, inst_valid}, 2'b01);
      tick();
    end
    inst_ready = 1'b1;
    tick();
    chk("hold_release", {imem_req, inst_valid, imem_addr}, {1'b1, 1'b0, 32'h8000_0004});
    drain();

    // redirect from HOLD without a handshake
    do_reset();
    imem_gnt = 1'b1;
    imem_rvalid = 1'b1;
    exp_addr.push_back(32'h8000_0000);
    tick();
    tick();
    imem_gnt = 1'b0;
    tick();
    br_taken = 1'b1;
    br_target = 32'h8000_0080;
    #1;
    chk("hold_redir_npc", next_pc, 32'h8000_0080);
    tick();
    br_taken = 1'b0;
    chk("hold_redir_req", {imem_req, inst_valid, imem_addr}, {1'b1, 1'b0, 32'h8000_0080});
    drain();

    // address wrap, then reset in WAIT with a stale response afterwards
    do_reset();
    imem_gnt = 1'b1;
    imem_rvalid = 1'b1;
    inst_ready = 1'b1;
    br_taken = 1'b1;
    br_target = 32'hFFFF_FFF8;
    exp_addr.push_back(32'hFFFF_FFF8);
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_inst.push_back({32'hFFFF_FFF8, 32'h0000_0007});
    tick();
    br_taken = 1'b0;
    tick();
    tick();
    tick();
    imem_rvalid = 1'b0;
    #1;
    chk("wrap_npc", next_pc, 32'h0000_0000);
    tick();
    chk("pre_rst_inst", {inst_pc, inst}, {32'hFFFF_FFF8, 32'h0000_0007});
    rst = 1'b1;
    #1;
    chk("rst_ctl", {imem_req, inst_valid, next_pc}, {1'b0, 1'b0, 32'h8000_0000});
    chk("rst_inst", {inst_pc, inst}, 64'h0);
    tick();
    rst = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    tick();
    tick();
    chk("stale_rvalid", {imem_req, inst_valid, imem_addr}, {1'b1, 1'b0, 32'h8000_0000});
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
